pipeline_hazard_ctrl: RTL
=========================

Name: pipeline_hazard_ctrl

Overview:
Central sequencing controller for the 5-stage 16-bit pipeline (fetch, decode, execute, memory, writeback).
- Tracks in-flight destination registers for the execute, memory and writeback stages.
- Generates forwarding selects, load-use stalls/bubbles and branch flush squashing.
- Generates the global `halt` that freezes every stage, including writeback, while memory is not ready.
- Sits beside decode; all stage modules consume its outputs.

Parameters:
- REG_W, 3, register index width (8 registers, r0 hardwired zero)
- CNT_W, 16, width of performance counters
- TIMEOUT, 64, memory-wait cycles before forced release (only with the optional feature)

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- dec_valid  in  1  decode holds a real instruction
- dec_ra  in  REG_W  source A index
- dec_rb  in  REG_W  source B index
- dec_uses_ra  in  1  instruction reads ra
- dec_uses_rb  in  1  instruction reads rb
- dec_tgt  in  REG_W  destination index
- dec_writes  in  1  instruction writes dec_tgt (false for SW/BEQ)
- dec_is_load  in  1  instruction is LW
- flush  in  1  taken branch/jump resolved in execute
- mem_req  in  1  memory stage is issuing an access this cycle
- mem_ready  in  1  memory completes the access this cycle
- stall  out  1  hold fetch and decode registers
- bubble_ex  out  1  inject bubble into execute
- squash  out  1  invalidate fetch and decode contents
- halt  out  1  global freeze of all stages
- fwd_a  out  2  source-A operand select
- fwd_b  out  2  source-B operand select
- stall_cnt  out  CNT_W  cycles with stall asserted, saturating
- wait_cnt  out  CNT_W  cycles with halt asserted, saturating
- mem_timeout  out  1  sticky timeout error (optional feature)

Behaviour:
- Three internal slots, EX, MEM and WB, each holding {valid, tgt, load}. A slot is "live" when valid and tgt != 0 and it writes.
- Slot advance:
  - Slots advance only when halt=0: WB<=MEM, MEM<=EX.
  - EX <= decode instruction if dec_valid && !stall && !squash; otherwise EX is loaded invalid.
  - halt=1 holds all slots.
- Load-use hazard:
  - Condition: a used source equals the EX tgt, the EX slot is live, and EX.load=1.
  - Response: stall=1 and bubble_ex=1, combinationally in the same cycle.
- Forward select, per source, highest priority first:
  - 01 = EX live and non-load match.
  - 10 = MEM live match (load data available).
  - 11 = WB live match.
  - 00 = register file.
  - Index 0 or an unused source always gives 00.
- Flush:
  - flush && !halt gives squash=1, and EX loads invalid next edge.
  - Flush overrides the load-use stall: stall=0 and bubble_ex=0 that cycle.
  - flush while halt=1 is ignored; the producer holds flush until halt drops.
- Memory-wait FSM:
  - States: IDLE, WAIT.
  - IDLE->WAIT on mem_req && !mem_ready.
  - WAIT->IDLE on mem_ready.
  - halt = (IDLE && mem_req && !mem_ready) || (WAIT && !mem_ready). No halt in the completion cycle.
- Counters: +1 per cycle of the respective condition, saturating at all-ones, never wrap.
- Reset (asynchronous, rst_n=0):
  - Slots invalid, FSM IDLE, counters 0, mem_timeout 0.
  - Therefore stall, bubble_ex, squash and halt are 0 unless inputs demand otherwise; fwd_* = 00.
  - Reset mid-wait abandons the access.

Optional Feature:
- Macro: HAZARD_TIMEOUT_EN.
- Defined:
  - An internal counter runs in WAIT.
  - On reaching TIMEOUT consecutive wait cycles: mem_timeout is set (sticky until reset), FSM returns to IDLE, halt drops, and further mem_req are ignored for halt purposes.
- Undefined: no counter, mem_timeout tied 0, and WAIT persists indefinitely.

Decomposition:
- Shared package pipe_pkg:
  - REG_W.
  - Forward encodings FWD_RF/FWD_EX/FWD_MEM/FWD_WB.
  - Opcode constants OP_SW=3'b100, OP_LW=3'b101, OP_BEQ=3'b110.
  - Slot struct type.
  - FSM state enum.
- One sub-module: mem_wait_fsm (FSM, halt, timeout logic).

Test Plan:
- Reset: rst_n=0 mid-WAIT -> halt=0, all counters 0, fwd_a=fwd_b=00 immediately.
- ADD r3 then ADD r4,r3,r3 back-to-back -> fwd_a=fwd_b=01. The next instruction reading r3 gets 10, the one after that 11.
- LW r2 then ADD r5,r2,r1 -> one cycle stall=1, bubble_ex=1, then fwd_a=10; stall_cnt=1.
- Write r0 followed by read of r0 -> fwd=00 and no stall.
- mem_req=1 with mem_ready low for 3 cycles -> halt=1 for exactly 3 cycles, slots frozen, wait_cnt=3. flush asserted during the wait is applied only after halt drops.
- Load-use and flush in the same cycle -> squash=1, stall=0, and EX invalid next cycle.
- With HAZARD_TIMEOUT_EN, TIMEOUT=4, mem_ready held low -> halt for 4 cycles, then mem_timeout=1 and halt=0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the 5-stage pipeline sequencing logic.
//   REG_W       register index width (r0 reads as zero and is never a hazard)
//   FWD_*       operand-select encodings driven on fwd_a / fwd_b
//   OP_*        opcodes of the instructions that need special hazard treatment
//   slot_t      in-flight destination record kept per downstream stage
//   mem_state_e memory-wait FSM states
package pipe_pkg;

    localparam int unsigned REG_W = 3;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EX  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b11;

    localparam logic [2:0] OP_SW  = 3'b100;
    localparam logic [2:0] OP_LW  = 3'b101;
    localparam logic [2:0] OP_BEQ = 3'b110;

    typedef struct packed {
        logic             valid;
        logic             writes;
        logic             load;
        logic [REG_W-1:0] tgt;
    } slot_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } mem_state_e;

    // A slot only matters for hazards when it really writes a non-zero register.
    function automatic logic slot_live(input slot_t s);
        return s.valid && s.writes && (s.tgt != '0);
    endfunction

endpackage

// File: rtl/mem_wait_fsm.sv
// Memory-wait tracker: raises the global freeze while an access is outstanding.
// Optional feature macro: HAZARD_TIMEOUT_EN (forced release after TIMEOUT halt cycles).
// Ports:
//   clk, rst_n      clock, async active-low reset
//   mem_req_i       memory stage issues an access this cycle
//   mem_ready_i     memory completes the access this cycle
//   halt_c_o        combinational freeze request
//   mem_timeout_o   sticky timeout flag (tied 0 without the feature)
module mem_wait_fsm
    import pipe_pkg::*;
#(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic mem_req_i,
    input  logic mem_ready_i,
    output logic halt_c_o,
    output logic mem_timeout_o
);

    mem_state_e state_q, state_d;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef HAZARD_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             tmo_q, tmo_d;

    // Wait-length counter and sticky timeout flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q <= '0;
            tmo_q     <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            tmo_q     <= tmo_d;
        end
    end

    // Next state / halt; the counter holds the number of halt cycles so far
    always_comb begin
        state_d   = state_q;
        tmo_cnt_d = tmo_cnt_q;
        tmo_d     = tmo_q;
        halt_c_o  = 1'b0;
        // After a timeout the memory side is considered broken: never freeze again.
        if (!tmo_q) begin
            case (state_q)
                ST_IDLE: begin
                    if (mem_req_i && !mem_ready_i) begin
                        halt_c_o  = 1'b1;
                        tmo_cnt_d = TMO_W'(1);
                        state_d   = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (mem_ready_i) begin
                        tmo_cnt_d = '0;
                        state_d   = ST_IDLE;
                    end else begin
                        halt_c_o  = 1'b1;
                        tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
            if (halt_c_o && (tmo_cnt_d >= TMO_W'(TIMEOUT))) begin
                tmo_d     = 1'b1;
                tmo_cnt_d = '0;
                state_d   = ST_IDLE;
            end
        end
    end

    assign mem_timeout_o = tmo_q;
`else
    // Next state / halt; WAIT persists until the access completes
    always_comb begin
        state_d  = state_q;
        halt_c_o = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (mem_req_i && !mem_ready_i) begin
                    halt_c_o = 1'b1;
                    state_d  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem_ready_i) begin
                    state_d = ST_IDLE;
                end else begin
                    halt_c_o = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign mem_timeout_o = 1'b0;

    // TIMEOUT has no effect when the forced release is not built in.
    if (TIMEOUT == 0) begin : g_timeout_unused
    end
`endif

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central hazard/sequencing controller for the 5-stage 16-bit pipeline.
// Optional feature macro: HAZARD_TIMEOUT_EN (memory-wait forced release, see mem_wait_fsm).
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   dec_*                       instruction currently held in decode
//   flush                       taken branch/jump resolved in execute
//   mem_req, mem_ready          memory-stage handshake
//   stall, bubble_ex, squash    combinational load-use / flush controls
//   halt                        combinational global freeze
//   fwd_a, fwd_b                combinational operand selects
//   stall_cnt, wait_cnt         registered saturating performance counters
//   mem_timeout                 registered sticky timeout flag
module pipeline_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned REG_W   = pipe_pkg::REG_W,
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             dec_valid,
    input  logic [REG_W-1:0] dec_ra,
    input  logic [REG_W-1:0] dec_rb,
    input  logic             dec_uses_ra,
    input  logic             dec_uses_rb,
    input  logic [REG_W-1:0] dec_tgt,
    input  logic             dec_writes,
    input  logic             dec_is_load,
    input  logic             flush,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             stall,
    output logic             bubble_ex,
    output logic             squash,
    output logic             halt,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] wait_cnt,
    output logic             mem_timeout
);

    slot_t ex_q, mem_q, wb_q, ex_d;
    logic  halt_c, load_use_c, squash_c, stall_c;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, wait_cnt_q, wait_cnt_d;

    mem_wait_fsm #(
        .TIMEOUT (TIMEOUT)
    ) u_mem_wait (
        .clk           (clk),
        .rst_n         (rst_n),
        .mem_req_i     (mem_req),
        .mem_ready_i   (mem_ready),
        .halt_c_o      (halt_c),
        .mem_timeout_o (mem_timeout)
    );

    // Youngest live producer wins; a load in EX has no data yet, so it never forwards.
    function automatic logic [1:0] fwd_sel(input logic used, input logic [REG_W-1:0] src,
                                           input slot_t ex, input slot_t mem, input slot_t wb);
        logic [1:0] sel;
        sel = FWD_RF;
        if (used && (src != '0)) begin
            if (slot_live(wb) && (wb.tgt == src))                sel = FWD_WB;
            if (slot_live(mem) && (mem.tgt == src))              sel = FWD_MEM;
            if (slot_live(ex) && !ex.load && (ex.tgt == src))    sel = FWD_EX;
        end
        return sel;
    endfunction

    // Hazard detection, flush priority and next EX contents
    always_comb begin
        load_use_c = slot_live(ex_q) && ex_q.load &&
                     ((dec_uses_ra && (dec_ra == ex_q.tgt)) ||
                      (dec_uses_rb && (dec_rb == ex_q.tgt)));
        // Flush is deferred while frozen; the producer keeps it asserted.
        squash_c   = flush && !halt_c;
        stall_c    = load_use_c && !squash_c;

        ex_d = '0;
        if (dec_valid && !stall_c && !squash_c) begin
            ex_d.valid  = 1'b1;
            ex_d.writes = dec_writes;
            ex_d.load   = dec_is_load;
            ex_d.tgt    = dec_tgt;
        end
    end

    assign stall     = stall_c;
    assign bubble_ex = stall_c;
    assign squash    = squash_c;
    assign halt      = halt_c;
    assign fwd_a     = fwd_sel(dec_uses_ra, dec_ra, ex_q, mem_q, wb_q);
    assign fwd_b     = fwd_sel(dec_uses_rb, dec_rb, ex_q, mem_q, wb_q);

    // In-flight destination tracking; everything holds while frozen
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else if (!halt_c) begin
            ex_q  <= ex_d;
            mem_q <= ex_q;
            wb_q  <= mem_q;
        end
    end

    // Saturating performance counters
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        if (stall_c && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (halt_c && (wait_cnt_q != '1))   wait_cnt_d  = wait_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            wait_cnt_q  <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign wait_cnt  = wait_cnt_q;

endmodule
